df_wr_ptr_full: RTL
===================

Name: df_wr_ptr_full

Overview:
Write-domain pointer and full-flag controller for the dual-clock FIFO.
- Keeps the binary write pointer and drives the memory write address and enable.
- Produces the registered Gray write pointer that the read-domain pointer synchronizer samples.
- Takes the Gray read pointer already synchronized into clk to generate full, almost_full, the fill level and a sticky overflow error.

Parameters:
ADDR_WIDTH, 3, memory address width; FIFO depth = 2**ADDR_WIDTH; pointer width P = ADDR_WIDTH+1 (default 4); must be >= 2.
AFULL_THRESH, 6, almost_full asserts when level >= this value; legal range 1..2**ADDR_WIDTH.

Ports:
clk  in  1  write-domain clock
rst_n  in  1  reset; asynchronous, active-low
winc  in  1  write request from producer
clr_ovf  in  1  synchronous clear of overflow
wq2_rptr  in  P  Gray read pointer, already synchronized into clk
waddr  out  ADDR_WIDTH  memory write address = wbin[ADDR_WIDTH-1:0]
wclken  out  1  memory write enable, combinational = winc & ~full
wptr  out  P  registered Gray write pointer, goes to the read-domain synchronizer
full  out  1  FIFO full, registered
almost_full  out  1  level >= AFULL_THRESH, registered
wlevel  out  P  fill level seen from the write side, registered, range 0..2**ADDR_WIDTH
overflow  out  1  sticky: a write was attempted while full

Behaviour:
- Reset (rst_n low, async): wbin=0, wptr=0, full=0, almost_full=0, wlevel=0, overflow=0.
  - waddr=0 follows from wbin.
  - Release is synchronous to clk; the first accepted write can occur on the first clk edge after release.
- Accept: a write is accepted when winc=1 && full=0 (i.e. wclken=1).
  - The memory captures at waddr on that same edge.
  - A write attempted while full is dropped; pointers do not move.
- Next-state values:
  - wbin_next = wbin + accept, modulo 2**P.
  - wgray_next = (wbin_next >> 1) ^ wbin_next.
- Registered on every clk edge: wbin <= wbin_next; wptr <= wgray_next.
  - wptr changes by exactly one bit per increment, so it is safe for multi-flop synchronization.
  - wptr is never driven from combinational logic.
- full <= (wgray_next == {~wq2_rptr[P-1:P-2], wq2_rptr[P-3:0]}).
  - Full rises on the edge of the write that fills the FIFO; there is zero-cycle lag between wptr and full.
- Read pointer conversion: rbin = Gray-to-binary of wq2_rptr (XOR prefix from MSB).
  - wlevel <= (wbin_next - rbin) mod 2**P.
  - almost_full <= ((wbin_next - rbin) mod 2**P) >= AFULL_THRESH.
- Pessimism: wq2_rptr lags the true read pointer by the synchronizer latency. full, almost_full and wlevel may overstate occupancy, never understate it. This is required behaviour, not a bug.
- Full deassertion: full falls on the first edge where a changed wq2_rptr breaks the equality, even if winc=0.
- Simultaneous events:
  - A write accepted on the same edge a read pointer advance arrives: both are applied, and full is evaluated on the combined next values.
  - winc=1 with full=1 in the same cycle as clr_ovf=1: overflow stays 1 (set wins over clear).
- Overflow: overflow <= 1 when winc && full; otherwise overflow <= 0 when clr_ovf; otherwise it holds.
- Wrap-around: wbin rolls from 2**P-1 to 0 with no special handling. The MSB (wrap bit) distinguishes full from empty.
- Reset mid-operation: all state clears immediately.
  - The read side must also be reset; behaviour with only one domain reset is undefined.

Test Plan:
1. Reset, then 8 back-to-back writes with wq2_rptr=0 -> wptr sequence 0x1,0x3,0x2,0x6,0x7,0x5,0x4,0xC; full=1 on the 8th write edge; wlevel=8; waddr 0..7; almost_full=1 from the 6th write edge.
2. Full with winc=1 for 3 cycles -> wclken=0, wptr stays 0xC, overflow=1 and sticky; then clr_ovf=1 with winc=0 -> overflow=0 next edge; clr_ovf=1 with winc=1 while full -> overflow stays 1.
3. Full, then wq2_rptr steps 0x0->0x1 -> full=0 and wlevel=7 on the next edge; one write -> full=1, wptr=0xD, waddr was 0.
4. Wrap: 16 writes interleaved with wq2_rptr tracking wptr 2 cycles behind -> wbin wraps 15->0, wptr returns 0x8->0x0, full never asserts, wlevel never exceeds 2.
5. Write accepted on the same edge wq2_rptr advances, at level 7 -> level stays 7, full=0; at level 8 with a simultaneous read advance -> full stays 1 on that edge only if equality still holds, else 0.
6. Assert rst_n low mid-burst between edges at level 5 -> all outputs 0 immediately without a clk edge; the first write after release uses waddr=0 and gives wptr=0x1.

Source files
------------

// File: rtl/df_wr_ptr_full.sv
// Write-domain pointer and full-flag controller for the dual-clock FIFO.
// Owns the binary write pointer, publishes its registered Gray form to the
// read domain, and derives full / almost_full / level / overflow from the
// Gray read pointer that has already been synchronized into clk.
module df_wr_ptr_full #(
    parameter int unsigned ADDR_WIDTH   = 3,
    parameter int unsigned AFULL_THRESH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  winc,
    input  logic                  clr_ovf,
    input  logic [ADDR_WIDTH:0]   wq2_rptr,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic                  wclken,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  overflow
);

    localparam int unsigned P = ADDR_WIDTH + 1;
    localparam logic [P-1:0] AF_LVL = AFULL_THRESH[P-1:0];

    logic [P-1:0] wbin;
    logic [P-1:0] wbin_next;
    logic [P-1:0] wgray_next;
    logic [P-1:0] rbin;
    logic [P-1:0] level_next;
    logic         accept;

    assign accept = winc & ~full;
    assign wclken = accept;
    assign waddr  = wbin[ADDR_WIDTH-1:0];

    // Next write pointer (binary and Gray) and occupancy after this edge.
    always_comb begin
        wbin_next  = wbin + {{(P-1){1'b0}}, accept};
        wgray_next = (wbin_next >> 1) ^ wbin_next;
        level_next = wbin_next - rbin;
    end

    // Gray-to-binary of the synchronized read pointer (XOR prefix from MSB).
    always_comb begin
        rbin        = '0;
        rbin[P-1]   = wq2_rptr[P-1];
        for (int unsigned i = 1; i < P; i++) begin
            rbin[P-1-i] = rbin[P-i] ^ wq2_rptr[P-1-i];
        end
    end

    // Pointer and status registers; full compares the next Gray write pointer
    // against the read pointer with its two MSBs inverted (one lap ahead).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin        <= '0;
            wptr        <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wlevel      <= '0;
        end else begin
            wbin        <= wbin_next;
            wptr        <= wgray_next;
            full        <= (wgray_next == {~wq2_rptr[P-1:P-2], wq2_rptr[P-3:0]});
            almost_full <= (level_next >= AF_LVL);
            wlevel      <= level_next;
        end
    end

    // Sticky overflow: a write attempt while full sets it and beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (winc && full) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule
